// File: rtl/sphere_pair_fetcher_pkg.sv
// fetch_pkg: shared state encoding, word/slot constants and pair-count helper for the sphere pair fetcher
package fetch_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT_RD, S_PRESENT, S_ADVANCE, S_DONE} state_e;
  typedef enum logic [1:0] {OFS_X, OFS_Y, OFS_Z, OFS_R} ofs_e;
  localparam logic [2:0] A_BASE = 3'd0;
  localparam logic [2:0] B_BASE = 3'd4;
  function automatic int npairs(input int n);
    return n * (n - 1) / 2;
  endfunction
endpackage

// File: rtl/sphere_pair_fetcher_loader.sv
// sphere_loader: issues four back-to-back reads for one sphere and tags each returning word with its pair_data slot
module sphere_loader import fetch_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int IDX_W = 2,
  parameter int WORDS_PER_OBJ = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic [IDX_W-1:0]  obj_i,
  input  logic [2:0]        slot_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              wr_en_o,
  output logic [2:0]        wr_slot_o,
  output logic              load_done_o
);
  ofs_e              cnt_q;
  logic              rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        slot_q, wr_slot_q;
  // a new go may land on the last issue cycle of the previous load, so it wins
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= OFS_X;
      slot_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_slot_q <= '0;
    end else begin
      wr_en_q   <= rd_en_q;
      wr_slot_q <= slot_q + {1'b0, cnt_q};
      if (go_i) begin
        rd_en_q <= 1'b1;
        addr_q  <= ADDR_W'(BASE_ADDR + int'(obj_i) * WORDS_PER_OBJ);
        cnt_q   <= OFS_X;
        slot_q  <= slot_i;
      end else if (rd_en_q) begin
        rd_en_q <= cnt_q != OFS_R;
        if (cnt_q != OFS_R) begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= ofs_e'(cnt_q + 2'd1);
        end
      end
    end
  end
  assign rd_en_o     = rd_en_q;
  assign addr_o      = addr_q;
  assign last_o      = rd_en_q && cnt_q == OFS_R;
  assign wr_en_o     = wr_en_q;
  assign wr_slot_o   = wr_slot_q;
  assign load_done_o = wr_en_q && wr_slot_q[1:0] == 2'(OFS_R);
endmodule

// File: rtl/sphere_pair_fetcher.sv
// sphere_pair_fetcher: walks all sphere pairs i<j in RAM, caching sphere A, and hands each pair to the collision core
module sphere_pair_fetcher import fetch_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NUM_OBJ = 4,
  parameter int WORDS_PER_OBJ = 4,
  parameter int BASE_ADDR = 0,
  localparam int IDX_W = (NUM_OBJ > 2) ? $clog2(NUM_OBJ) : 1,
  localparam int CNT_W = (npairs(NUM_OBJ) > 0) ? $clog2(npairs(NUM_OBJ) + 1) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [8*DATA_W-1:0] pair_data,
  output logic [IDX_W-1:0]    id_a,
  output logic [IDX_W-1:0]    id_b,
  output logic                pair_valid,
  input  logic                core_done,
  output logic                busy,
  output logic                end_of_memory,
  output logic [CNT_W-1:0]    pair_count
);
  state_e              state_q, nxt_q;
  logic [IDX_W-1:0]    i_q, j_q, id_a_q, id_b_q, obj;
  logic                pv_q, eom_q, adv_a, adv_b, restart, go, load_b, last, wr_en, load_done;
  logic [CNT_W-1:0]    pc_q;
  logic [8*DATA_W-1:0] pd_q;
  logic [2:0]          slot, wr_slot;
  // the next load is launched on the same edge that accepts start/core_done so reads begin one cycle later
  always_comb begin
    adv_b   = int'(j_q) < NUM_OBJ - 1;
    adv_a   = int'(i_q) < NUM_OBJ - 2;
    restart = (state_q == S_IDLE || state_q == S_DONE) && start;
    go      = (restart && NUM_OBJ >= 2) || (state_q == S_LOAD_A && last) ||
              (state_q == S_PRESENT && core_done && (adv_b || adv_a));
    load_b  = state_q == S_LOAD_A || (state_q == S_PRESENT && adv_b);
    obj     = restart ? '0 : state_q == S_LOAD_A ? j_q : adv_b ? j_q + 1'b1 : i_q + 1'b1;
    slot    = load_b ? B_BASE : A_BASE;
  end
  sphere_loader #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .WORDS_PER_OBJ(WORDS_PER_OBJ), .BASE_ADDR(BASE_ADDR)
  ) u_loader (
    .clk(clk), .rst(rst), .go_i(go), .obj_i(obj), .slot_i(slot),
    .rd_en_o(mem_rd_en), .addr_o(mem_addr), .last_o(last),
    .wr_en_o(wr_en), .wr_slot_o(wr_slot), .load_done_o(load_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      nxt_q   <= S_IDLE;
      i_q     <= '0;
      j_q     <= IDX_W'(1);
      id_a_q  <= '0;
      id_b_q  <= '0;
      pv_q    <= 1'b0;
      eom_q   <= 1'b0;
      pc_q    <= '0;
      pd_q    <= '0;
    end else begin
      if (wr_en) pd_q[wr_slot*DATA_W +: DATA_W] <= mem_rdata;
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_q <= NUM_OBJ >= 2 ? S_LOAD_A : S_DONE;
          i_q     <= '0;
          j_q     <= IDX_W'(1);
          eom_q   <= NUM_OBJ < 2;
          pc_q    <= '0;
        end
        S_LOAD_A: if (last) state_q <= S_LOAD_B;
        S_LOAD_B: if (last) state_q <= S_WAIT_RD;
        S_WAIT_RD: if (load_done) begin
          state_q <= S_PRESENT;
          pv_q    <= 1'b1;
          id_a_q  <= i_q;
          id_b_q  <= j_q;
        end
        S_PRESENT: if (core_done) begin
          state_q <= S_ADVANCE;
          pv_q    <= 1'b0;
          pc_q    <= pc_q + 1'b1;
          nxt_q   <= adv_b ? S_LOAD_B : adv_a ? S_LOAD_A : S_DONE;
          if (adv_b) j_q <= obj;
          else if (adv_a) begin
            i_q <= obj;
            j_q <= obj + 1'b1;
          end
        end
        S_ADVANCE: begin
          state_q <= nxt_q;
          eom_q   <= nxt_q == S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign pair_data     = pd_q;
  assign id_a          = id_a_q;
  assign id_b          = id_b_q;
  assign pair_valid    = pv_q;
  assign busy          = state_q != S_IDLE && state_q != S_DONE;
  assign end_of_memory = eom_q;
  assign pair_count    = pc_q;
endmodule

// File: doc/sphere_pair_fetcher.md
Name: sphere_pair_fetcher

Overview:
- Parametrised fetch engine between sphere memory and the dCollideSpheres core.
- Walks every unique sphere pair (i<j) in a synchronous-read RAM, loads 8 words (x1,y1,z1,r1,x2,y2,z2,r2), and presents them with pair_valid.
- Waits for the core's done pulse, then advances; raises end_of_memory after the last pair.
- Replaces the fixed single-pair fetch/end_of_memory handshake with N-object all-pairs traversal and sphere-A caching.

Parameters:
- DATA_W, 32, word width (IEEE-754 single).
- ADDR_W, 10, RAM address width.
- NUM_OBJ, 4, number of spheres stored; legal range 0..2**ADDR_W/WORDS_PER_OBJ.
- WORDS_PER_OBJ, 4, words per sphere; offsets 0..3 = x,y,z,r; extra words are skipped.
- BASE_ADDR, 0, address of sphere 0, word 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin traversal; sampled in IDLE or DONE only
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM address
- mem_rdata  in  DATA_W  RAM data, valid one cycle after mem_rd_en
- pair_data  out  8*DATA_W  word k at [k*DATA_W +: DATA_W]; k=0..3 sphere A x,y,z,r; k=4..7 sphere B
- id_a  out  IDX_W  index i of sphere A; IDX_W = max(1,$clog2(NUM_OBJ))
- id_b  out  IDX_W  index j of sphere B
- pair_valid  out  1  pair_data/id stable, core may compute
- core_done  in  1  single-cycle done pulse from the collision core
- busy  out  1  high in any state except IDLE and DONE
- end_of_memory  out  1  all pairs processed
- pair_count  out  CNT_W  completed pairs; CNT_W = $clog2(NUM_OBJ*(NUM_OBJ-1)/2+1), min 1

Behaviour:
- Reset: all outputs 0, state IDLE, i=0, j=1. Reset mid-operation aborts immediately; in-flight read data is discarded.
- FSM states:
  - IDLE: on start, go to LOAD_A if NUM_OBJ>=2; otherwise go to DONE.
  - LOAD_A: issue 4 consecutive reads of sphere i, then go to LOAD_B.
  - LOAD_B: issue 4 reads of sphere j.
  - WAIT_RD: capture the final word.
  - PRESENT: pair_valid=1.
  - ADVANCE: update indices.
  - DONE: end_of_memory=1.
- Addressing: addr = BASE_ADDR + obj*WORDS_PER_OBJ + w, w=0..3. mem_rd_en high exactly on issue cycles; mem_addr holds its last value otherwise.
- Capture: data for the read issued in cycle t is written into the pair_data slot at the clk edge ending cycle t+1. Reads are back-to-back, one per cycle.
- Latency, with start sampled at edge 0:
  - read addresses appear in cycles 1..8;
  - pair_valid goes high in cycle 10.
- PRESENT:
  - pair_data, id_a and id_b are frozen while pair_valid=1.
  - core_done in cycle d: pair_valid=0 and pair_count+1 from cycle d+1; go to ADVANCE.
  - core_done outside PRESENT is ignored.
- ADVANCE, with N = NUM_OBJ:
  - If j<N-1: j++, reload only B (sphere A is cached). Next pair_valid at d+6.
  - Else if i<N-2: i++, j=i+1, reload A and B. Next pair_valid at d+10.
  - Else go to DONE.
- DONE:
  - end_of_memory=1 and pair_data holds the last pair.
  - start restarts the traversal: i=0, j=1, end_of_memory and pair_count cleared in the next cycle.
- start while busy is ignored.
- Total pairs = N(N-1)/2. N=0 or 1 reaches DONE one cycle after start, with pair_count=0.
- No arithmetic on data; words pass through bit-exact.

Decomposition:
- Shared package (fetch_pkg):
  - state encoding enum;
  - word-offset constants OFS_X=0, OFS_Y=1, OFS_Z=2, OFS_R=3;
  - slot index constants A_BASE=0, B_BASE=4;
  - function npairs(n) for CNT_W.
- One natural sub-module: sphere_loader. It issues 4 reads for a given object index, handles read-latency capture, and pulses load_done. The parent FSM instantiates it once and selects the A or B slot.

Test Plan:
- NUM_OBJ=2, sphere0 = {0xBEFC475E, 0, 0x3FC00000, 0x3F000000}, sphere1 = {0x3EFC475E, 0, 0x3FC00000, 0x3F000000}. Pulse start -> pair_valid in cycle 10 with those 8 words, id_a=0, id_b=1. core_done -> pair_count=1, end_of_memory=1, busy=0.
- NUM_OBJ=4, core_done 3 cycles after each pair_valid -> exactly 6 pairs, in order (0,1)(0,2)(0,3)(1,2)(1,3)(2,3). Pairs with unchanged i show 4 reads and 6-cycle spacing; pairs where i changes show 8 reads and 10-cycle spacing. End state: pair_count=6, end_of_memory=1.
- Hold core_done low for 50 cycles in PRESENT -> pair_valid and pair_data stay constant. A core_done pulse in LOAD_B -> ignored, pair_count unchanged.
- Assert rst during LOAD_B of pair (1,2) -> next cycle all outputs 0, state IDLE. A later start restarts at (0,1).
- In DONE, pulse start -> end_of_memory=0 and pair_count=0 next cycle; full traversal repeats identically. start while busy -> no effect.
- NUM_OBJ=1, start -> end_of_memory=1 at cycle 1, no mem_rd_en ever, pair_valid never asserted.
